// File: rtl/ecc27_pkg.sv
// Shared definitions for the 27/7 ECC write encoder and its read-side checker.
// Latency: n/a (constants, types and a pure function).
// Backpressure: n/a.
package ecc27_pkg;

  localparam int DATA_W   = 27;
  localparam int PARITY_W = 7;
  localparam int CW_WIDTH = DATA_W + PARITY_W;  // 34-bit codeword {parity, data}

  typedef enum logic [1:0] {
    INJ_NONE   = 2'b00,
    INJ_SINGLE = 2'b01,
    INJ_DOUBLE = 2'b10
  } inj_mode_t;

  // Parity matrix shared bit-for-bit with the read-side checker; any change
  // here must land in both places at once or clean words stop decoding to 0.
  function automatic logic [PARITY_W-1:0] ecc27_encode(input logic [DATA_W-1:0] d);
    logic [PARITY_W-1:0] p;
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11] ^ d[13] ^ d[15]
         ^ d[17] ^ d[19] ^ d[21] ^ d[23] ^ d[25] ^ d[26];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12] ^ d[13] ^ d[16]
         ^ d[17] ^ d[20] ^ d[21] ^ d[24] ^ d[25];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14] ^ d[15] ^ d[16]
         ^ d[17] ^ d[22] ^ d[23] ^ d[24] ^ d[25];
    p[3] = (^d[10:4]) ^ (^d[25:18]);
    p[4] = ^d[25:11];
    p[5] = d[26];
    p[6] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[12] ^ d[14]
         ^ d[17] ^ d[18] ^ d[21] ^ d[23] ^ d[24] ^ d[26];
    return p;
  endfunction

endpackage

// File: rtl/ecc_27_parity_gen.sv
// 27-bit payload to 7-bit parity generator (pure combinational wrapper of ecc27_encode).
// Latency: 0 cycles. Ports: data (27) in, parity (7) out.
// Backpressure: none, no state.
module ecc_27_parity_gen
  import ecc27_pkg::*;
(
  input  logic [DATA_W-1:0]   data,
  output logic [PARITY_W-1:0] parity
);

  assign parity = ecc27_encode(data);

endmodule

// File: rtl/ecc_27_wr_enc.sv
// Write-side ECC stage: encodes 27-bit payloads into a registered 34-bit codeword,
// with a one-shot single/double bit-flip injector and saturating word/injection counters.
// Latency: 1 cycle. Backpressure: in_ready = !out_valid | out_ready; output holds while out_ready=0.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data; out_valid/out_ready/
// out_data/out_parity; inj_arm/inj_mode/inj_pos0/inj_pos1 in, inj_busy/inj_done out;
// word_cnt/inj_cnt statistics.
module ecc_27_wr_enc
  import ecc27_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W,
  parameter int PARITY_WIDTH = PARITY_W,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_parity,
  input  logic                    inj_arm,
  input  logic [1:0]              inj_mode,
  input  logic [5:0]              inj_pos0,
  input  logic [5:0]              inj_pos1,
  output logic                    inj_busy,
  output logic                    inj_done,
  output logic [CNT_WIDTH-1:0]    word_cnt,
  output logic [CNT_WIDTH-1:0]    inj_cnt
);

  typedef enum logic {ST_IDLE, ST_ARMED} inj_state_t;

  localparam logic [CW_WIDTH-1:0] CW_ONE = CW_WIDTH'(1);

  inj_state_t            state, state_nxt;
  inj_mode_t             mode_q;
  logic [5:0]            pos0_q, pos1_q;
  logic                  xfer;
  logic                  arm_ok;
  logic [PARITY_W-1:0]   parity;
  logic [CW_WIDTH-1:0]   flip_mask;
  logic [CW_WIDTH-1:0]   cw_next;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign arm_ok   = (inj_mode == INJ_SINGLE) || (inj_mode == INJ_DOUBLE);

  ecc_27_parity_gen u_parity_gen (
    .data   (in_data),
    .parity (parity)
  );

  // Shifting past bit 33 yields zero, so out-of-range indices flip nothing,
  // and XOR of two equal one-hot masks cancels for a same-position double.
  always_comb begin
    flip_mask = CW_ONE << pos0_q;
    if (mode_q == INJ_DOUBLE) begin
      flip_mask = (CW_ONE << pos0_q) ^ (CW_ONE << pos1_q);
    end
  end

  // Parity always covers the clean payload; flips are applied afterwards.
  assign cw_next = {parity, in_data} ^ (inj_done ? flip_mask : '0);

  // Injection FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= INJ_NONE;
      pos0_q <= '0;
      pos1_q <= '0;
    end else begin
      state <= state_nxt;
      // Latch only on a successful arm from IDLE; arms while ARMED are ignored.
      if (state == ST_IDLE && inj_arm && arm_ok) begin
        mode_q <= inj_mode_t'(inj_mode);
        pos0_q <= inj_pos0;
        pos1_q <= inj_pos1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    inj_done  = 1'b0;
    inj_busy  = 1'b0;
    case (state)
      ST_IDLE: begin
        // An arm in the same cycle as a transfer targets the following word.
        if (inj_arm && arm_ok) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        inj_busy = 1'b1;
        if (xfer && !rst) begin
          inj_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= '0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= cw_next[DATA_W-1:0];
      out_parity <= cw_next[CW_WIDTH-1:DATA_W];
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
      inj_cnt  <= '0;
    end else begin
      if (xfer && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
      if (inj_done && inj_cnt != '1) inj_cnt <= inj_cnt + 1'b1;
    end
  end

endmodule

// File: doc/ecc_27_wr_enc.md
Name: ecc_27_wr_enc

Overview:
- Write-side ECC stage for the FIFO ecc_module path. Accepts 27-bit payload words over valid/ready and computes the 7-bit parity.
- Presents a registered 34-bit codeword to the FIFO write port.
- The parity matrix is bit-identical to the read-side 27/7 checker, so a clean codeword yields syndrome 0 there.
- Includes a one-shot single/double-bit error injector, plus word and injection counters, for read-path verification.

Parameters:
- DATA_WIDTH, 27, payload width; fixed by the parity matrix, no other value supported.
- PARITY_WIDTH, 7, parity width; fixed.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  payload valid.
- in_ready  out  1  stage can accept a payload.
- in_data  in  27  payload.
- out_valid  out  1  codeword valid.
- out_ready  in  1  FIFO accepts the codeword.
- out_data  out  27  codeword data field (codeword bits 26:0).
- out_parity  out  7  codeword parity field (codeword bits 33:27).
- inj_arm  in  1  one-cycle pulse that arms injection.
- inj_mode  in  2  sampled at arm: 00 none, 01 single flip, 10 double flip, 11 reserved (treated as 00).
- inj_pos0  in  6  first flip index into the 34-bit codeword; sampled at arm.
- inj_pos1  in  6  second flip index; sampled at arm; used only in mode 10.
- inj_busy  out  1  injection armed and not yet applied.
- inj_done  out  1  one-cycle pulse in the cycle the injected word is accepted.
- word_cnt  out  CNT_WIDTH  codewords accepted at input; saturates at all-ones.
- inj_cnt  out  CNT_WIDTH  injected codewords; saturates.

Behaviour:
- Parity equations, XOR reduction over the listed data bits:
  - p0: 0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26
  - p1: 0,2,3,5,6,9,10,12,13,16,17,20,21,24,25
  - p2: 1,2,3,7,8,9,10,14,15,16,17,22,23,24,25
  - p3: 4..10, 18..25
  - p4: 11..25
  - p5: 26
  - p6: 0,1,2,4,5,7,10,11,12,14,17,18,21,23,24,26
- Pipeline: one register stage, latency 1.
  - in_ready = !out_valid | out_ready.
  - Transfer occurs when in_valid & in_ready; the codeword is registered and out_valid=1 next cycle.
  - If out_valid & out_ready & no new transfer, out_valid drops to 0.
  - Full throughput: one word per cycle under continuous out_ready=1.
  - Under out_ready=0, out_data/out_parity/out_valid hold stable.
- Parity is always computed on the unmodified payload. Injection XORs the selected codeword bits after encoding.
- Injection FSM states: IDLE, ARMED.
  - IDLE + inj_arm with mode 01/10 → ARMED; mode and positions latch.
  - ARMED + input transfer → flips applied to that word, inj_done=1, inj_cnt+1, → IDLE.
  - inj_arm while ARMED is ignored.
  - inj_arm with mode 00/11 stays in IDLE, no effect.
  - inj_busy=1 exactly in ARMED.
- Flip positions: index ≥34 flips nothing for that position. Mode 10 with pos0==pos1 flips nothing, yet still counts as injected and pulses inj_done.
- Arm and transfer in the same cycle while in IDLE: injection is NOT applied to that word; it applies to the next transfer.
- Counters increment on input transfer and hold at all-ones.
- Reset values:
  - out_valid=0, out_data=0, out_parity=0, inj_busy=0, inj_done=0, word_cnt=0, inj_cnt=0; FSM=IDLE.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-ARMED discards the pending injection. Reset with a held codeword drops it (out_valid=0).

Decomposition:
- Shared package ecc27_pkg holds:
  - DATA_WIDTH/PARITY_WIDTH constants.
  - CW_WIDTH=34 constant.
  - inj_mode enum (INJ_NONE, INJ_SINGLE, INJ_DOUBLE).
  - ecc27_encode function. The read-side checker is to import this same function.
- One natural sub-module: ecc_27_parity_gen, combinational, 27 in / 7 out, wrapping ecc27_encode.

Test Plan:
- Reset, then in_data=27'h0 → next cycle out_valid=1, out_data=0, out_parity=7'h00, word_cnt=1.
- in_data=27'h0000001 → out_parity=7'b1000011. Then in_data=27'h4000000 → out_parity=7'b1100001 (1-cycle latency each, back-to-back).
- Arm mode 01, pos0=3, then send in_data=0 → out_data=27'h8, out_parity=0, inj_done pulse, inj_cnt=1. Feeding this codeword to the checker gives syndrome 7'b0000111 and sbit_err=1.
- Arm mode 10, pos0=0, pos1=30, send in_data=0 → out_data=27'h1, out_parity=7'b0001000; checker reports dbit_err=1.
- out_ready=0 for 5 cycles with in_valid=1 → the first word is held stable, in_ready=0, word_cnt increments by 1 only. On release, the words stream one per cycle with none lost or duplicated.
- Arm mode 01, assert rst before any transfer → inj_busy=0. The next word is unmodified, with inj_cnt=0 and word_cnt=0 after reset.
